// File: rtl/apb_timer_slave_pkg.sv
// Shared definitions for the APB timer slave: register offsets, bit positions
// and the protocol FSM encoding.
package apb_timer_slave_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_t;

   localparam logic [31:0] REG_SCRATCH = 32'h0000_0000;
   localparam logic [31:0] REG_CTRL    = 32'h0000_0004;
   localparam logic [31:0] REG_COUNT   = 32'h0000_0008;
   localparam logic [31:0] REG_COMPARE = 32'h0000_000C;
   localparam logic [31:0] REG_STATUS  = 32'h0000_0010;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int CTRL_CLR_BIT    = 2;

   localparam int STATUS_MATCH_BIT  = 0;
   localparam int STATUS_ERRCNT_LSB = 8;
   localparam int STATUS_ERRCLR_BIT = 31;

endpackage

// File: rtl/apb_timer_slave_monitor.sv
// APB2 protocol tracker: follows the SETUP/ACCESS sequence of the selected slave
// and pulses o_err for every malformed cycle.
module apb_protocol_monitor
   import apb_timer_slave_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sel,
   input  logic        i_enable,
   input  logic        i_write,
   input  logic [31:0] i_addr,
   output logic [1:0]  o_state,
   output logic        o_err
);

   apb_state_t  r_state;
   apb_state_t  w_state_nxt;
   logic [31:0] r_setup_addr;
   logic        r_setup_write;
   logic        w_mismatch;

   // Address/direction are captured whenever a setup phase is entered, so the
   // access phase can be compared against them.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= IDLE;
         r_setup_addr  <= '0;
         r_setup_write <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt == SETUP) begin
            r_setup_addr  <= i_addr;
            r_setup_write <= i_write;
         end
      end
   end

   always_comb begin
      w_state_nxt = IDLE;
      case (r_state)
         IDLE:    if (i_sel && !i_enable) w_state_nxt = SETUP;
         SETUP: begin
            if (i_sel && i_enable) w_state_nxt = ACCESS;
            else if (i_sel)        w_state_nxt = SETUP;
         end
         ACCESS:  if (i_sel && !i_enable) w_state_nxt = SETUP;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_mismatch = (i_addr != r_setup_addr) || (i_write != r_setup_write);

   always_comb begin
      o_err = 1'b0;
      case (r_state)
         IDLE:    o_err = i_sel && i_enable;
         SETUP:   o_err = !(i_sel && i_enable) || w_mismatch;
         ACCESS:  o_err = i_sel && i_enable;
         default: o_err = 1'b0;
      endcase
   end

   assign o_state = r_state;

endmodule

// File: rtl/apb_timer_slave.sv
// APB2 completer with scratch/control/compare registers, a free-running counter
// with match interrupt, and a saturating count of protocol errors.
module apb_timer_slave
   import apb_timer_slave_pkg::*;
#(
   parameter int SEL_IDX  = 0,
   parameter int OFFSET_W = 8,
   parameter int ERRCNT_W = 8
) (
   input  logic        Hclk,
   input  logic        Hreset,
   input  logic [2:0]  Pselx,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        irq
);

   logic                w_sel;
   logic [1:0]          w_state;
   logic                w_err;
   logic                w_commit;
   logic                w_rd_load;
   logic [31:0]         w_off;
   logic [31:0]         w_rdata;
   logic [31:0]         w_ctrl_rd;
   logic [31:0]         w_status_rd;
   logic [31:0]         w_count_nxt;
   logic                w_wr_scratch;
   logic                w_wr_ctrl;
   logic                w_wr_compare;
   logic                w_wr_status;
   logic                w_clr;
   logic                w_match_set;
   logic                w_match_w1c;
   logic                w_errcnt_clr;

   logic [31:0]         r_scratch;
   logic                r_en;
   logic                r_irq_en;
   logic [31:0]         r_count;
   logic [31:0]         r_compare;
   logic                r_match;
   logic [ERRCNT_W-1:0] r_errcnt;
   logic [31:0]         r_prdata;

   assign w_sel = |(Pselx & (3'b001 << SEL_IDX));

   apb_protocol_monitor u_mon (
      .i_clk    (Hclk),
      .i_rst    (Hreset),
      .i_sel    (w_sel),
      .i_enable (Penable),
      .i_write  (Pwrite),
      .i_addr   (Paddr),
      .o_state  (w_state),
      .o_err    (w_err)
   );

   // Word offset within the decoded window; byte lane bits and upper bits drop out.
   always_comb begin
      w_off                 = '0;
      w_off[OFFSET_W-1:2]   = Paddr[OFFSET_W-1:2];
   end

   // The monitor still sits in SETUP during the access cycle of a good transfer.
   assign w_commit  = w_sel && Penable && Pwrite && (w_state == SETUP);
   assign w_rd_load = w_sel && !Penable;

   assign w_wr_scratch = w_commit && (w_off == REG_SCRATCH);
   assign w_wr_ctrl    = w_commit && (w_off == REG_CTRL);
   assign w_wr_compare = w_commit && (w_off == REG_COMPARE);
   assign w_wr_status  = w_commit && (w_off == REG_STATUS);

   assign w_clr        = w_wr_ctrl && Pwdata[CTRL_CLR_BIT];
   assign w_match_w1c  = w_wr_status && Pwdata[STATUS_MATCH_BIT];
   assign w_errcnt_clr = w_wr_status && Pwdata[STATUS_ERRCLR_BIT];

   always_comb begin
      if (w_clr)     w_count_nxt = '0;
      else if (r_en) w_count_nxt = r_count + 32'd1;
      else           w_count_nxt = r_count;
   end

   assign w_match_set = r_en && (w_count_nxt == r_compare);

   always_comb begin
      w_ctrl_rd                  = '0;
      w_ctrl_rd[CTRL_EN_BIT]     = r_en;
      w_ctrl_rd[CTRL_IRQ_EN_BIT] = r_irq_en;
   end

   always_comb begin
      w_status_rd                                  = '0;
      w_status_rd[STATUS_MATCH_BIT]                = r_match;
      w_status_rd[STATUS_ERRCNT_LSB +: ERRCNT_W]   = r_errcnt;
   end

   always_comb begin
      w_rdata = '0;
      case (w_off)
         REG_SCRATCH: w_rdata = r_scratch;
         REG_CTRL:    w_rdata = w_ctrl_rd;
         REG_COUNT:   w_rdata = r_count;
         REG_COMPARE: w_rdata = r_compare;
         REG_STATUS:  w_rdata = w_status_rd;
         default:     w_rdata = '0;
      endcase
   end

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         r_scratch <= '0;
         r_en      <= 1'b0;
         r_irq_en  <= 1'b0;
         r_compare <= '0;
      end else begin
         if (w_wr_scratch) r_scratch <= Pwdata;
         if (w_wr_ctrl) begin
            r_en     <= Pwdata[CTRL_EN_BIT];
            r_irq_en <= Pwdata[CTRL_IRQ_EN_BIT];
         end
         if (w_wr_compare) r_compare <= Pwdata;
      end
   end

   // A match detected in the same cycle as a W1C keeps the flag set.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         r_count <= '0;
         r_match <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         if (w_match_set)      r_match <= 1'b1;
         else if (w_match_w1c) r_match <= 1'b0;
      end
   end

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         r_errcnt <= '0;
      end else if (w_errcnt_clr) begin
         r_errcnt <= w_err ? ERRCNT_W'(1) : '0;
      end else if (w_err && !(&r_errcnt)) begin
         r_errcnt <= r_errcnt + ERRCNT_W'(1);
      end
   end

   // Read data is valid only through the access cycle; zero otherwise.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) r_prdata <= '0;
      else        r_prdata <= w_rd_load ? w_rdata : '0;
   end

   assign Prdata = r_prdata;
   assign irq    = r_match && r_irq_en;

endmodule
